// File: rtl/i2c_line_driver_if.sv
// Pad-side and protocol-side signals of the I2C target line driver.
// The protocol FSM side uses master; the line driver uses slave.
interface i2c_line_driver_if #(
    parameter int DATA_BYTES = 2
);
    localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    logic [4:0]              state;
    logic [8*DATA_BYTES-1:0] read_value;
    logic                    stretch_req;
    logic                    SCL_in;
    logic                    SDA_in;
    logic                    SCL_out;
    logic                    SDA_out;
    logic                    SCL_ena;
    logic                    SDA_ena;
    logic                    scl_fall;
    logic                    scl_rise;
    logic                    master_nack;
    logic [IDX_W-1:0]        byte_idx;

    modport master (
        output state, read_value, stretch_req, SCL_in, SDA_in,
        input  SCL_out, SDA_out, SCL_ena, SDA_ena, scl_fall, scl_rise,
               master_nack, byte_idx
    );

    modport slave (
        input  state, read_value, stretch_req, SCL_in, SDA_in,
        output SCL_out, SDA_out, SCL_ena, SDA_ena, scl_fall, scl_rise,
               master_nack, byte_idx
    );
endinterface

// File: rtl/i2c_line_driver.sv
// I2C target-side SDA/SCL line driver: synchronisers, SCL edge pulses, read bursts, ACK sampling, stretching.
// Define I2C_GLITCH_FILTER_EN to insert a FILTER_CYCLES glitch filter after the synchronisers.
module i2c_line_driver #(
    parameter int DATA_BYTES    = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    i2c_line_driver_if.slave bus
);
    localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

    typedef enum logic [4:0] {
        ST_IDLE          = 5'd0,
        ST_START         = 5'd1,
        ST_DEVICE_ADDR   = 5'd2,
        ST_READ_OR_WRITE = 5'd3,
        ST_ADDR_ACK      = 5'd4,
        ST_REG_ADDR      = 5'd5,
        ST_REG_ACK       = 5'd6,
        ST_WRITE         = 5'd7,
        ST_WRITE_ACK     = 5'd8,
        ST_READ          = 5'd9,
        ST_READ_ACK      = 5'd10,
        ST_STOP          = 5'd11
    } i2c_state_e;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_q, sda_q, scl_prev;
    logic                   fall, rise;
    logic [7:0]             cur_byte;

    logic             sda_out_q, sda_ena_q, scl_ena_q, fall_q, rise_q, nack_q;
    logic             sda_out_d, sda_ena_d, scl_ena_d, fall_d, rise_d, nack_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.SCL_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.SDA_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             scl_filt, sda_filt;
    logic [CNT_W-1:0] scl_cnt, sda_cnt;

    // Counter restarts whenever the synchronised input agrees with the filtered value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            if (scl_sync[SYNC_STAGES-1] == scl_filt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CNT_LAST) begin
                scl_filt <= ~scl_filt;
                scl_cnt  <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[SYNC_STAGES-1] == sda_filt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CNT_LAST) begin
                sda_filt <= ~sda_filt;
                sda_cnt  <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    assign scl_q = scl_filt;
    assign sda_q = sda_filt;
`else
    logic unused_filter_cfg;
    assign unused_filter_cfg = ^FILTER_CYCLES;
    assign scl_q = scl_sync[SYNC_STAGES-1];
    assign sda_q = sda_sync[SYNC_STAGES-1];
`endif

    always_comb begin
        fall       = scl_prev & ~scl_q;
        rise       = ~scl_prev & scl_q;
        cur_byte   = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (byte_idx_q == IDX_W'(i)) cur_byte = bus.read_value[8*i +: 8];
        end
        sda_out_d  = sda_out_q;
        sda_ena_d  = sda_ena_q;
        scl_ena_d  = scl_ena_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        nack_d     = nack_q;
        fall_d     = 1'b0;
        rise_d     = 1'b0;
        if (ena) begin
            fall_d = fall;
            rise_d = rise;
            if (fall) begin
                case (bus.state)
                    ST_IDLE, ST_START, ST_DEVICE_ADDR, ST_READ_OR_WRITE,
                    ST_REG_ADDR, ST_WRITE, ST_READ_ACK, ST_STOP: sda_ena_d = 1'b0;
                    ST_ADDR_ACK, ST_REG_ACK, ST_WRITE_ACK: begin
                        sda_ena_d = 1'b1;
                        sda_out_d = 1'b0;
                    end
                    ST_READ: begin
                        sda_ena_d = 1'b1;
                        sda_out_d = cur_byte[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                    default: ;
                endcase
                if (bus.state != ST_READ) bit_cnt_d = 3'd7;
                if (bus.state == ST_IDLE || bus.state == ST_START || bus.state == ST_REG_ACK)
                    byte_idx_d = '0;
                if (bus.state == ST_IDLE || bus.state == ST_START || bus.state == ST_STOP)
                    nack_d = 1'b0;
            end
            if (rise && bus.state == ST_READ_ACK) begin
                if (sda_q) nack_d = 1'b1;
                else byte_idx_d = (byte_idx_q == LAST_IDX) ? '0 : byte_idx_q + 1'b1;
            end
            // Stretch is armed only by a falling edge but released immediately on request drop.
            if (!bus.stretch_req) scl_ena_d = 1'b0;
            else if (fall) scl_ena_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_prev   <= 1'b1;
            sda_out_q  <= 1'b0;
            sda_ena_q  <= 1'b0;
            scl_ena_q  <= 1'b0;
            fall_q     <= 1'b0;
            rise_q     <= 1'b0;
            nack_q     <= 1'b0;
            bit_cnt_q  <= 3'd7;
            byte_idx_q <= '0;
        end else begin
            scl_prev   <= scl_q;
            sda_out_q  <= sda_out_d;
            sda_ena_q  <= sda_ena_d;
            scl_ena_q  <= scl_ena_d;
            fall_q     <= fall_d;
            rise_q     <= rise_d;
            nack_q     <= nack_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign bus.SCL_out     = 1'b0;
    assign bus.SDA_out     = sda_out_q;
    assign bus.SDA_ena     = sda_ena_q;
    assign bus.SCL_ena     = scl_ena_q;
    assign bus.scl_fall    = fall_q;
    assign bus.scl_rise    = rise_q;
    assign bus.master_nack = nack_q;
    assign bus.byte_idx    = byte_idx_q;
endmodule
